// File: rtl/fetch_queue_if.sv
// fetch_queue_if -- handshake and bus bundle around the instruction fetch queue.
//
// Valid/ready rule for every channel in this bundle: a transfer happens in a
// cycle where valid && ready are both high at the rising clock edge. Once the
// producer raises valid, it must not retract it or change the payload
// until the transfer happens. A redirect is the exception: it withdraws a
// pending request or instruction. imem_resp_* has no ready signal. The fetch
// queue always accepts responses.
//
// Signals:
//   imem_req_valid/ready/addr  fetch request to instruction memory
//   imem_resp_valid/data       in-order instruction words returning from memory
//   redirect_valid/pc          control-flow redirect (flush + restart)
//   inst_valid/ready/inst/pc   instruction channel to decode
//
// Modports:
//   master  the fetch queue itself
//   slave   the environment (memory + decode + redirect source)
interface fetch_queue_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue -- instruction fetch queue feeding decode.
//
// This block issues sequential word fetches to instruction memory. It keeps the
// returned words and their PCs in an in-order FIFO and hands them to decode
// with a valid/ready handshake. A redirect clears the FIFO and restarts fetch
// at the new PC. Responses that are still in flight at that point are counted
// and dropped when they arrive.
//
// Parameters:
//   DEPTH     FIFO entries (power of two, 2..16). Also caps the total of
//             buffered entries and outstanding fetches.
//   RESET_PC  first fetch address after reset.
//
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   bus (master)     fetch request/response, redirect and decode channels
//   o_dbg_count      current FIFO occupancy
//   o_dbg_inflight   fetches issued but not yet answered
//   o_dbg_drop       answers still to be discarded after a redirect
//
// Build option:
//   FETCH_QUEUE_BYPASS_EN  A response that meets an empty queue is shown to
//                          decode in the same cycle. Without this macro, every
//                          decode output comes from FIFO registers.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  fetch_queue_if.master              bus,
  output logic [$clog2(DEPTH+1)-1:0] o_dbg_count,
  output logic [$clog2(DEPTH+1)-1:0] o_dbg_inflight,
  output logic [$clog2(DEPTH+1)-1:0] o_dbg_drop
);

  localparam int              AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              CW     = $clog2(DEPTH + 1);
  localparam logic [CW:0]     L_CAP  = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0]   L_FULL = CW'(DEPTH);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [31:0]   r_mem_inst [DEPTH];
  logic [31:0]   r_mem_pc   [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_drop;

  logic [31:0]   w_redirect_pc;
  logic [CW:0]   w_credit_used;
  logic          w_req_valid;
  logic          w_req_fire;
  logic          w_resp_drop;
  logic          w_resp_keep;
  logic          w_bypass;
  logic          w_bypass_take;
  logic          w_inst_valid;
  logic          w_pop;
  logic          w_push;
  logic          w_push_wr;

  assign w_redirect_pc = {bus.redirect_pc[31:2], 2'b00};

  // Credit check: buffered entries plus outstanding fetches never exceed
  // DEPTH, so every response that is not dropped has a free slot waiting.
  assign w_credit_used = {1'b0, r_count} + {1'b0, r_inflight};
  assign w_req_valid   = !reset && !bus.redirect_valid && (w_credit_used < L_CAP);
  assign w_req_fire    = w_req_valid && bus.imem_req_ready;

  // Discard a response if it belongs to the old stream (drop backlog). Also
  // discard one that lands in the cycle of a redirect.
  assign w_resp_drop = bus.imem_resp_valid && (bus.redirect_valid || (r_drop != '0));
  assign w_resp_keep = bus.imem_resp_valid && !w_resp_drop;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_bypass = bus.imem_resp_valid && (r_count == '0) && (r_drop == '0) &&
                    !bus.redirect_valid;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_bypass_take = w_bypass && bus.inst_ready;
  assign w_inst_valid  = ((r_count != '0) && !bus.redirect_valid) || w_bypass;
  assign w_pop         = (r_count != '0) && !bus.redirect_valid && bus.inst_ready;
  assign w_push        = w_resp_keep && !w_bypass_take;
  // A push into a full FIFO is never written. The credit check should make it
  // impossible, and the assertion below flags it if it happens.
  assign w_push_wr     = w_push && (r_count != L_FULL);

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_fetch_pc;
  assign bus.inst_valid     = w_inst_valid;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bus.inst    = w_bypass ? bus.imem_resp_data : r_mem_inst[r_rd_ptr];
  assign bus.inst_pc = w_bypass ? r_resp_pc          : r_mem_pc[r_rd_ptr];
`else
  assign bus.inst    = r_mem_inst[r_rd_ptr];
  assign bus.inst_pc = r_mem_pc[r_rd_ptr];
`endif

  assign o_dbg_count    = r_count;
  assign o_dbg_inflight = r_inflight;
  assign o_dbg_drop     = r_drop;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_inflight <= '0;
      r_drop     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_inst[i] <= '0;
        r_mem_pc[i]   <= '0;
      end
    end else begin
      // inflight counts every outstanding fetch, dropped or not. No request
      // is issued during a redirect, so this one update covers both cases.
      r_inflight <= r_inflight + CW'(w_req_fire) - CW'(bus.imem_resp_valid);

      if (bus.redirect_valid) begin
        r_fetch_pc <= w_redirect_pc;
        r_resp_pc  <= w_redirect_pc;
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        r_count    <= '0;
        // Earlier drops are already part of inflight. So after a redirect,
        // every fetch still outstanding belongs to an abandoned stream. That
        // excludes the response arriving now, which is discarded here.
        r_drop     <= r_inflight - CW'(bus.imem_resp_valid);
      end else begin
        if (w_req_fire) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (w_resp_keep) begin
          r_resp_pc <= r_resp_pc + 32'd4;
        end
        if (w_resp_drop) begin
          r_drop <= r_drop - CW'(1);
        end
        if (w_push_wr) begin
          r_mem_inst[r_wr_ptr] <= bus.imem_resp_data;
          r_mem_pc[r_wr_ptr]   <= r_resp_pc;
          r_wr_ptr             <= r_wr_ptr + AW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
        r_count <= r_count + CW'(w_push_wr) - CW'(w_pop);
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(w_push && (r_count == L_FULL)));

endmodule

// File: tb/tb_fetch_queue.sv
`timescale 1ns/1ps
module tb_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam int          CW       = $clog2(DEPTH + 1);
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_queue_if bus();
  logic [CW-1:0] dbg_count, dbg_inflight, dbg_drop;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .o_dbg_count    (dbg_count),
    .o_dbg_inflight (dbg_inflight),
    .o_dbg_drop     (dbg_drop)
  );

  // ---------------- scoreboard / memory model state ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mem_lat = 1;
  int mem_last_due = -1;
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];
  bit          mem_stale_q[$];
  logic [63:0] exp_q[$];          // {inst, pc} in expected decode order
  logic [31:0] model_pc;
  logic [31:0] pop_log[$];

  bit          obs_fire, obs_req_v, obs_inst_valid, obs_pop, obs_resp;
  logic [31:0] obs_addr, obs_inst, obs_pc;
  int          fire_cnt, pop_cnt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h5A00};
  endfunction

  // ---------------- driver: one clock cycle ----------------
  task automatic step(input bit req_rdy, input bit inst_rdy, input bit redir,
                      input logic [31:0] rpc);
    int n_stale;
    int n_live;
    int occ_m;
    int infl_m;
    int due;
    bit byp_m;
    bit exp_req_v;
    bit exp_inst_v;
    logic [63:0] head;
    n_stale = 0;
    foreach (mem_stale_q[i]) if (mem_stale_q[i]) n_stale++;
    infl_m = mem_addr_q.size();
    n_live = infl_m - n_stale;
    occ_m  = exp_q.size() - n_live;
    if (!reset) begin
      checks++;
      if (dbg_count !== CW'(occ_m) || dbg_inflight !== CW'(infl_m) || dbg_drop !== CW'(n_stale)) begin
        errors++;
        $display("FAIL state cyc=%0d count/inflight/drop got %0d/%0d/%0d want %0d/%0d/%0d",
                 cyc, dbg_count, dbg_inflight, dbg_drop, occ_m, infl_m, n_stale);
      end
    end
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    obs_resp = 1'b0;
    if (!reset && mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = mem_word(mem_addr_q[0]);
      obs_resp = 1'b1;
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
      void'(mem_stale_q.pop_front());
    end
    byp_m      = BYP && obs_resp && (occ_m == 0) && (n_stale == 0) && !redir;
    exp_req_v  = !redir && ((occ_m + infl_m) < DEPTH);
    exp_inst_v = ((occ_m > 0) && !redir) || byp_m;
    if (redir) begin
      foreach (mem_stale_q[i]) mem_stale_q[i] = 1'b1;
      exp_q.delete();
      model_pc = {rpc[31:2], 2'b00};
    end
    bus.imem_req_ready = req_rdy;
    bus.inst_ready     = inst_rdy;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    #1;
    obs_req_v      = bus.imem_req_valid;
    obs_fire       = bus.imem_req_valid && req_rdy;
    obs_addr       = bus.imem_req_addr;
    obs_inst_valid = bus.inst_valid;
    obs_inst       = bus.inst;
    obs_pc         = bus.inst_pc;
    obs_pop        = bus.inst_valid && inst_rdy;
    if (!reset) begin
      checks++;
      if (bus.imem_req_valid !== exp_req_v) begin
        errors++;
        $display("FAIL req_valid cyc=%0d got %b want %b", cyc, bus.imem_req_valid, exp_req_v);
      end
      checks++;
      if (bus.inst_valid !== exp_inst_v) begin
        errors++;
        $display("FAIL inst_valid cyc=%0d got %b want %b", cyc, bus.inst_valid, exp_inst_v);
      end
      if (obs_fire) begin
        checks++;
        if (obs_addr !== model_pc) begin
          errors++;
          $display("FAIL req_addr cyc=%0d got %h want %h", cyc, obs_addr, model_pc);
        end
        due = cyc + mem_lat;
        if (due <= mem_last_due) due = mem_last_due + 1;
        mem_last_due = due;
        mem_addr_q.push_back(obs_addr);
        mem_due_q.push_back(due);
        mem_stale_q.push_back(1'b0);
        exp_q.push_back({mem_word(model_pc), model_pc});
        model_pc = model_pc + 32'd4;
        fire_cnt++;
      end
      if (obs_pop) begin
        pop_cnt++;
        pop_log.push_back(obs_pc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_inst cyc=%0d got pc %h inst %h want none", cyc, obs_pc, obs_inst);
        end else begin
          head = exp_q.pop_front();
          if ({obs_inst, obs_pc} !== head) begin
            errors++;
            $display("FAIL inst cyc=%0d got %h/%h want %h/%h", cyc, obs_inst, obs_pc,
                     head[63:32], head[31:0]);
          end
        end
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    mem_addr_q.delete();
    mem_due_q.delete();
    mem_stale_q.delete();
    exp_q.delete();
    pop_log.delete();
    mem_last_due = -1;
    model_pc = RESET_PC;
    repeat (2) step(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_dut();
    checks++;
    if (bus.imem_req_valid !== 1'b0 || bus.imem_req_addr !== RESET_PC) begin
      errors++;
      $display("FAIL reset_req got v=%b addr=%h want v=0 addr=%h", bus.imem_req_valid,
               bus.imem_req_addr, RESET_PC);
    end
    checks++;
    if (bus.inst_valid !== 1'b0 || bus.inst !== 32'h0 || bus.inst_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_inst got v=%b inst=%h pc=%h want 0/0/0", bus.inst_valid, bus.inst, bus.inst_pc);
    end
    checks++;
    if (dbg_count !== '0 || dbg_inflight !== '0 || dbg_drop !== '0) begin
      errors++;
      $display("FAIL reset_counts got %0d/%0d/%0d want 0/0/0", dbg_count, dbg_inflight, dbg_drop);
    end
    reset = 1'b0;
  endtask

  task automatic test_free_run();
    reset_dut();
    reset = 1'b0;
    mem_lat = 1;
    fire_cnt = 0;
    repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0);
    pop_cnt = 0;
    repeat (12) step(1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if (fire_cnt !== 16) begin
      errors++;
      $display("FAIL free_run_requests got %0d want 16", fire_cnt);
    end
    checks++;
    if (pop_cnt !== 12) begin
      errors++;
      $display("FAIL free_run_bubbles got %0d pops want 12", pop_cnt);
    end
    checks++;
    if (pop_log.size() < 3 || pop_log[0] !== 32'h0 || pop_log[1] !== 32'h4 || pop_log[2] !== 32'h8) begin
      errors++;
      $display("FAIL free_run_pcs got %0d entries want 0,4,8 first", pop_log.size());
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] first_addr;
    reset_dut();
    reset = 1'b0;
    mem_lat = 1;
    fire_cnt = 0;
    repeat (10) step(1'b1, 1'b0, 1'b0, 32'h0);
    checks++;
    if (fire_cnt !== 4 || obs_req_v !== 1'b0) begin
      errors++;
      $display("FAIL bp_requests got %0d last_valid=%b want 4 / 0", fire_cnt, obs_req_v);
    end
    checks++;
    if (dbg_count !== CW'(4)) begin
      errors++;
      $display("FAIL bp_occupancy got %0d want 4", dbg_count);
    end
    fire_cnt = 0;
    pop_log.delete();
    first_addr = 32'hFFFF_FFFF;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      if (obs_fire && fire_cnt == 1) first_addr = obs_addr;
    end
    checks++;
    if (pop_log.size() < 4 || pop_log[0] !== 32'h0 || pop_log[1] !== 32'h4 ||
        pop_log[2] !== 32'h8 || pop_log[3] !== 32'hC) begin
      errors++;
      $display("FAIL bp_drain got %0d entries want 0,4,8,c in order", pop_log.size());
    end
    checks++;
    if (first_addr !== 32'h10) begin
      errors++;
      $display("FAIL bp_resume got %h want 00000010", first_addr);
    end
  endtask

  task automatic test_redirect_inflight();
    logic [31:0] first_addr;
    reset_dut();
    reset = 1'b0;
    mem_lat = 3;
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h0000_1002);
    checks++;
    if (dbg_drop !== CW'(2) || dbg_count !== '0) begin
      errors++;
      $display("FAIL redir_drop got drop=%0d count=%0d want 2/0", dbg_drop, dbg_count);
    end
    fire_cnt = 0;
    pop_log.delete();
    first_addr = 32'hFFFF_FFFF;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      if (obs_fire && fire_cnt == 1) first_addr = obs_addr;
    end
    checks++;
    if (first_addr !== 32'h1000) begin
      errors++;
      $display("FAIL redir_addr got %h want 00001000", first_addr);
    end
    checks++;
    if (pop_log.size() == 0 || pop_log[0] !== 32'h1000) begin
      errors++;
      $display("FAIL redir_first_pc got %0d entries want first 00001000", pop_log.size());
    end
  endtask

  task automatic test_redirect_coincident();
    reset_dut();
    reset = 1'b0;
    mem_lat = 2;
    repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0200);
    checks++;
    if (dbg_count !== '0 || dbg_drop !== CW'(1)) begin
      errors++;
      $display("FAIL coinc_first got count=%0d drop=%0d want 0/1", dbg_count, dbg_drop);
    end
    step(1'b1, 1'b1, 1'b1, 32'h0000_0300);
    checks++;
    if (dbg_count !== '0 || dbg_drop !== '0) begin
      errors++;
      $display("FAIL coinc_second got count=%0d drop=%0d want 0/0", dbg_count, dbg_drop);
    end
    pop_log.delete();
    repeat (12) step(1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if (pop_log.size() == 0 || pop_log[0] !== 32'h300) begin
      errors++;
      $display("FAIL coinc_first_pc got %0d entries want first 00000300", pop_log.size());
    end
  endtask

  task automatic test_pc_wrap();
    reset_dut();
    reset = 1'b0;
    mem_lat = 1;
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFB);
    pop_log.delete();
    repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if (pop_log.size() < 3 || pop_log[0] !== 32'hFFFF_FFF8 || pop_log[1] !== 32'hFFFF_FFFC ||
        pop_log[2] !== 32'h0000_0000) begin
      errors++;
      $display("FAIL pc_wrap got %0d entries want fffffff8,fffffffc,00000000", pop_log.size());
    end
  endtask

  task automatic test_bypass();
    bit found;
    reset_dut();
    reset = 1'b0;
    mem_lat = 2;
    step(1'b1, 1'b1, 1'b0, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      found = obs_resp;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL bypass_timeout got no response want one within 10 cycles");
    end else begin
      checks++;
      if (obs_inst_valid !== BYP) begin
        errors++;
        $display("FAIL bypass_same_cycle got %b want %b", obs_inst_valid, BYP);
      end
      checks++;
      if (dbg_count !== CW'(BYP ? 0 : 1)) begin
        errors++;
        $display("FAIL bypass_occupancy got %0d want %0d", dbg_count, BYP ? 0 : 1);
      end
      step(1'b0, 1'b1, 1'b0, 32'h0);
      checks++;
      if (obs_inst_valid !== !BYP) begin
        errors++;
        $display("FAIL bypass_next_cycle got %b want %b", obs_inst_valid, !BYP);
      end
    end
  endtask

  task automatic test_random();
    int guard;
    reset_dut();
    reset = 1'b0;
    for (int i = 0; i < 600; i++) begin
      mem_lat = $urandom_range(1, 4);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 29) == 0, $urandom);
    end
    guard = 0;
    while ((exp_q.size() != 0 || mem_addr_q.size() != 0) && guard < 60) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      guard++;
    end
    checks++;
    if (exp_q.size() != 0 || mem_addr_q.size() != 0) begin
      errors++;
      $display("FAIL random_drain got %0d pending want 0", exp_q.size());
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset = 1'b1;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    bus.inst_ready      = 1'b0;
    @(negedge clk);
    test_reset();
    test_free_run();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_coincident();
    test_pc_wrap();
    test_bypass();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
